vote_tally_tx: RTL

- Reads the three 8-bit party tallies produced by the vote logger and sends them off-chip as one framed serial report.
- Intended for a remote tally station.
- Sits beside the LED display path and uses the same mode semantics: mode 0 = voting, mode 1 = results.
- The report is sent as 8N1 async serial, LSB first, one frame per accepted request.

---
 rtl/vote_pkg.sv | 9 +
 rtl/uart_byte_tx.sv | 82 ++++++++
 rtl/vote_tally_tx.sv | 70 +++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared widths, frame constants and the serialiser state type for the
// vote tally serial reporter.
package vote_pkg;
  localparam int TALLY_W     = 8;
  localparam int FRAME_BYTES = 5;
  localparam logic [TALLY_W-1:0] DEFAULT_FRAME_HEADER = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_byte_tx.sv
// One 8N1 byte serialiser, LSB first. A load during the final stop-bit cycle
// chains straight into the next start bit so frames have no inter-byte gap.
module uart_byte_tx
  import vote_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic [TALLY_W-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t          r_state;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [TALLY_W-1:0] r_shift;
  logic               r_tx;
  logic               r_busy;
  logic               w_wrap;
  logic               w_done;
  logic               w_start;

  assign w_wrap  = (r_baud == BAUD_LAST);
  assign w_done  = (r_state == STOP) && w_wrap;
  assign w_start = i_load && ((r_state == IDLE) || w_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else if (w_start) begin
      r_state <= START;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= i_data;
      r_tx    <= 1'b0;
      r_busy  <= 1'b1;
    end else if (r_state != IDLE) begin
      if (w_wrap) begin
        r_baud <= '0;
        case (r_state)
          START: begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          DATA: begin
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = w_done;
endmodule

// File: rtl/vote_tally_tx.sv
// Snapshots the three party tallies on an accepted results-mode request and
// sends header, tallies and XOR checksum as one back-to-back 8N1 frame.
module vote_tally_tx
  import vote_pkg::*;
#(
  parameter int                 CLKS_PER_BIT = 16,
  parameter logic [TALLY_W-1:0] FRAME_HEADER = DEFAULT_FRAME_HEADER
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_mode,
  input  logic               i_report_req,
  input  logic [TALLY_W-1:0] i_party1_count,
  input  logic [TALLY_W-1:0] i_party2_count,
  input  logic [TALLY_W-1:0] i_party3_count,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_frame_done
);
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  // Bytes 1..4 of the frame; the header is a constant and never stored.
  logic [FRAME_BYTES-2:0][TALLY_W-1:0] r_shadow;
  logic [2:0]         r_byte_idx;
  logic               r_frame_done;
  logic               w_accept;
  logic               w_load;
  logic [TALLY_W-1:0] w_load_data;
  logic               w_byte_busy;
  logic               w_byte_done;

  assign w_accept    = i_report_req && i_mode && !w_byte_busy;
  assign w_load      = w_accept || (w_byte_done && (r_byte_idx != LAST_BYTE));
  assign w_load_data = w_accept ? FRAME_HEADER : r_shadow[r_byte_idx[1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow     <= '0;
      r_byte_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_shadow[0] <= i_party1_count;
        r_shadow[1] <= i_party2_count;
        r_shadow[2] <= i_party3_count;
        r_shadow[3] <= FRAME_HEADER ^ i_party1_count ^ i_party2_count ^ i_party3_count;
        r_byte_idx  <= '0;
      end else if (w_byte_done) begin
        if (r_byte_idx == LAST_BYTE) r_frame_done <= 1'b1;
        else                         r_byte_idx   <= r_byte_idx + 3'd1;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_data (w_load_data),
    .o_tx   (o_tx),
    .o_busy (w_byte_busy),
    .o_done (w_byte_done)
  );

  assign o_busy       = w_byte_busy;
  assign o_frame_done = r_frame_done;
endmodule
